// File: rtl/configf_pkg.sv
// Shared definitions for the configuration-register sequencer: FSM state
// encoding, read-flag position, retry limit and the ADC register constants.
package configf_pkg;

  // One-hot state encoding with S_IDLE in the MSB
  typedef enum logic [5:0] {
    S_IDLE  = 6'b100000,
    S_ISSUE = 6'b010000,
    S_WAIT  = 6'b001000,
    S_NEXT  = 6'b000100,
    S_DONE  = 6'b000010,
    S_ERR   = 6'b000001
  } state_e;

  // Read flag lives in the MSB of the default 8-bit register address
  localparam int unsigned READ_FLAG_POS = 7;

  // Timeout retries allowed per entry when retry support is built in
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned RETRY_W   = 2;

  // ADC register constants
  localparam logic [7:0]  ADC_CRM_ADDR  = 8'h01;
  localparam logic [15:0] ADC_MODE_WORD = 16'h0130;

  // Turn a register address into its read form
  function automatic logic [7:0] rd_addr(input logic [7:0] reg_addr);
    return reg_addr | 8'(1 << READ_FLAG_POS);
  endfunction

endpackage

// File: rtl/configf_tbl.sv
// Command table for the sequencer: one synchronous write port, one
// asynchronous read port. Contents are not reset.
//   clk     : clock
//   we      : write enable (already qualified by the caller)
//   wr_idx  : write index
//   wr_data : entry {addr, data}
//   rd_idx  : read index
//   rd_data : entry at rd_idx (combinational)
module configf_tbl #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ENT_W       = 24
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(NUM_ENTRIES)-1:0] wr_idx,
  input  logic [ENT_W-1:0]               wr_data,
  input  logic [$clog2(NUM_ENTRIES)-1:0] rd_idx,
  output logic [ENT_W-1:0]               rd_data
);

  logic [ENT_W-1:0] mem [NUM_ENTRIES];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Asynchronous read port
  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/configf_seq.sv
// Configuration sequencer: walks a table of {address, payload} entries and
// issues each one as a single-cycle command strobe, waiting for the host's
// completion pulse (bounded by a timeout) before moving to the next entry.
// Optional build macro CONFIGF_SEQ_RETRY_EN: a timeout re-issues the same
// entry up to MAX_RETRY times before flagging an error.
//   clk, reset (sync, active-high)
//   tbl_we/tbl_idx/tbl_addr/tbl_data : table load port (honoured only when idle)
//   seq_len, seq_start               : sequence length and start pulse
//   user_cmd_done_in                 : host completion pulse
//   user_cmd_en_out/user_addr_out/user_wrrd_num_out : command strobe + payload
//   seq_busy, seq_done, seq_err, err_idx            : status
module configf_seq
  import configf_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tbl_we,
  input  logic [$clog2(NUM_ENTRIES)-1:0]   tbl_idx,
  input  logic [ADDR_W-1:0]                tbl_addr,
  input  logic [DATA_W-1:0]                tbl_data,
  input  logic [$clog2(NUM_ENTRIES):0]     seq_len,
  input  logic                             seq_start,
  input  logic                             user_cmd_done_in,
  output logic                             user_cmd_en_out,
  output logic [ADDR_W-1:0]                user_addr_out,
  output logic [DATA_W-1:0]                user_wrrd_num_out,
  output logic                             seq_busy,
  output logic                             seq_done,
  output logic                             seq_err,
  output logic [$clog2(NUM_ENTRIES)-1:0]   err_idx
);

  localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);
  localparam int unsigned LEN_W  = IDX_W + 1;
  localparam int unsigned ENT_W  = ADDR_W + DATA_W;
  localparam int unsigned TCNT_W = (TIMEOUT_CYC >= 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                err_d;
  logic [IDX_W-1:0]    err_idx_d;
  logic                en_d, busy_d, done_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   data_d;
  logic [ENT_W-1:0]    rd_ent_c;
  logic                tbl_wr_c, len_ok_c, last_c, tmo_c;

`ifdef CONFIGF_SEQ_RETRY_EN
  logic [RETRY_W-1:0]  retry_q, retry_d;
`endif

  assign len_ok_c = (seq_len != '0) && (seq_len <= LEN_W'(NUM_ENTRIES));
  assign tbl_wr_c = tbl_we && (state_q == S_IDLE) &&
                    ({1'b0, tbl_idx} < LEN_W'(NUM_ENTRIES));
  assign last_c   = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
  assign tmo_c    = (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));

  // Table read follows the next index so the registered payload lines up
  // with the strobe cycle
  configf_tbl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ENT_W       (ENT_W)
  ) u_tbl (
    .clk     (clk),
    .we      (tbl_wr_c),
    .wr_idx  (tbl_idx),
    .wr_data ({tbl_addr, tbl_data}),
    .rd_idx  (idx_d),
    .rd_data (rd_ent_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tcnt_d    = '0;
    err_d     = seq_err;
    err_idx_d = err_idx;
`ifdef CONFIGF_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          err_d     = 1'b0;
          err_idx_d = '0;
          idx_d     = '0;
          len_d     = seq_len;
`ifdef CONFIGF_SEQ_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = len_ok_c ? S_ISSUE : S_DONE;
        end
      end
      // A done pulse during the strobe cycle is deliberately not looked at
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (user_cmd_done_in) begin
          state_d = S_NEXT;
        end else if (tmo_c) begin
`ifdef CONFIGF_SEQ_RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = S_ERR;
          end
`else
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = S_ERR;
`endif
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      S_NEXT: begin
        if (last_c) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
`ifdef CONFIGF_SEQ_RETRY_EN
          retry_d = '0;
`endif
          state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    en_d   = (state_d == S_ISSUE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    // Payload is presented from the strobe until the wait resolves
    if ((state_d == S_ISSUE) || (state_d == S_WAIT)) begin
      {addr_d, data_d} = rd_ent_c;
    end else begin
      addr_d = '0;
      data_d = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= S_IDLE;
      idx_q             <= '0;
      len_q             <= '0;
      tcnt_q            <= '0;
      user_cmd_en_out   <= 1'b0;
      user_addr_out     <= '0;
      user_wrrd_num_out <= '0;
      seq_busy          <= 1'b0;
      seq_done          <= 1'b0;
      seq_err           <= 1'b0;
      err_idx           <= '0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      len_q             <= len_d;
      tcnt_q            <= tcnt_d;
      user_cmd_en_out   <= en_d;
      user_addr_out     <= addr_d;
      user_wrrd_num_out <= data_d;
      seq_busy          <= busy_d;
      seq_done          <= done_d;
      seq_err           <= err_d;
      err_idx           <= err_idx_d;
    end
  end

`ifdef CONFIGF_SEQ_RETRY_EN
  // Per-entry retry counter
  always_ff @(posedge clk) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

endmodule

// File: tb/tb_configf_seq.sv
// Bench for configf_seq: table-driven sequence vectors plus hand-written
// reset / busy-interference / early-done sequences. Expected strobes are
// queued from a bench-side table model and popped as strobes appear.
module tb_configf_seq;
  import configf_pkg::*;

  localparam int NE       = 8;
  localparam int TMO      = 16;
  localparam int DONE_DLY = 5;
`ifdef CONFIGF_SEQ_RETRY_EN
  localparam int RETRIES  = 3;
`else
  localparam int RETRIES  = 0;
`endif

  logic        clk;
  logic        reset;
  logic        tbl_we;
  logic [2:0]  tbl_idx;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_data;
  logic [3:0]  seq_len;
  logic        seq_start;
  logic        user_cmd_done_in;
  logic        user_cmd_en_out;
  logic [7:0]  user_addr_out;
  logic [15:0] user_wrrd_num_out;
  logic        seq_busy;
  logic        seq_done;
  logic        seq_err;
  logic [2:0]  err_idx;

  configf_seq #(
    .NUM_ENTRIES (NE),
    .ADDR_W      (8),
    .DATA_W      (16),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .tbl_we            (tbl_we),
    .tbl_idx           (tbl_idx),
    .tbl_addr          (tbl_addr),
    .tbl_data          (tbl_data),
    .seq_len           (seq_len),
    .seq_start         (seq_start),
    .user_cmd_done_in  (user_cmd_done_in),
    .user_cmd_en_out   (user_cmd_en_out),
    .user_addr_out     (user_addr_out),
    .user_wrrd_num_out (user_wrrd_num_out),
    .seq_busy          (seq_busy),
    .seq_done          (seq_done),
    .seq_err           (seq_err),
    .err_idx           (err_idx)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    int len;
    int stall;
    bit exp_err;
    int exp_eidx;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          last_strobe_cyc = 0;
  bit          prev_en = 0;
  logic [7:0]  held_addr = '0;
  exp_t        exp_q[$];
  logic [7:0]  m_addr [NE];
  logic [15:0] m_data [NE];
  bit          stall_on;
  logic [7:0]  stall_addr;
  logic        resp_done;
  logic        manual_done;
  bit          resp_active;
  int          resp_cnt;
  vec_t        vecs [9];

  assign user_cmd_done_in = resp_done | manual_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe monitor / scoreboard
  always @(negedge clk) begin
    if (user_cmd_en_out === 1'b1) begin
      exp_t e;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      held_addr = user_addr_out;
      check("strobe_single_cycle", 32'(prev_en), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got addr %0h, expected no strobe", user_addr_out);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr", 32'(user_addr_out), 32'(e.a));
        check("strobe_data", 32'(user_wrrd_num_out), 32'(e.d));
      end
    end else if (prev_en && seq_busy === 1'b1) begin
      check("addr_hold", 32'(user_addr_out), 32'(held_addr));
    end
    prev_en = (user_cmd_en_out === 1'b1);
  end

  // Host responder: done pulse DONE_DLY cycles after each non-stalled strobe
  initial begin
    resp_done   = 1'b0;
    resp_active = 1'b0;
    resp_cnt    = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (seq_busy !== 1'b1) begin
        resp_active = 1'b0;
      end else if (resp_active) begin
        if (resp_cnt == 1) begin
          resp_done   = 1'b1;
          resp_active = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
      if (user_cmd_en_out === 1'b1 && !(stall_on && user_addr_out == stall_addr)) begin
        resp_active = 1'b1;
        resp_cnt    = DONE_DLY;
      end
    end
  end

  task automatic wr(input int i, input logic [7:0] a, input logic [15:0] d);
    tbl_we   = 1'b1;
    tbl_idx  = 3'(i);
    tbl_addr = a;
    tbl_data = d;
    tick();
    tbl_we   = 1'b0;
  endtask

  task automatic push_exp(input int len, input int stall);
    for (int i = 0; i < len; i++) begin
      int reps;
      reps = (i == stall) ? 1 + RETRIES : 1;
      for (int r = 0; r < reps; r++) exp_q.push_back({m_addr[i], m_data[i]});
      if (i == stall) break;
    end
  endtask

  // mode 0: plain, 1: table write + start while busy, 2: done during first strobe
  task automatic run_seq(input int len, input int stall, input bit exp_err,
                         input int exp_eidx, input int mode, input string tag);
    int n_exp;
    int waited;
    bit got;
    tick();
    exp_q.delete();
    strobe_cnt = 0;
    stall_on   = (stall >= 0);
    stall_addr = (stall >= 0) ? m_addr[stall] : 8'h00;
    if (len >= 1 && len <= NE) push_exp(len, stall);
    n_exp = exp_q.size();
    seq_len   = 4'(len);
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    if (mode == 2) manual_done = 1'b1;
    waited = 0;
    got    = 0;
    while (!got && waited < 400) begin
      @(negedge clk);
      if (seq_done === 1'b1 || seq_err === 1'b1) begin
        got = 1;
      end else begin
        tick();
        manual_done = 1'b0;
        waited++;
        if (mode == 1 && waited == 3) begin
          tbl_we    = 1'b1;
          tbl_idx   = 3'd0;
          tbl_addr  = 8'hAA;
          tbl_data  = 16'hBEEF;
          seq_len   = 4'd1;
          seq_start = 1'b1;
        end else if (mode == 1 && waited == 4) begin
          tbl_we    = 1'b0;
          seq_start = 1'b0;
        end
      end
    end
    check({tag, "_finished"}, 32'(got), 32'd1);
    check({tag, "_done"}, 32'(seq_done), 32'(!exp_err));
    check({tag, "_err"}, 32'(seq_err), 32'(exp_err));
    if (exp_err) begin
      check({tag, "_err_idx"}, 32'(err_idx), 32'(exp_eidx));
      check({tag, "_timeout_cycles"}, 32'(cyc - last_strobe_cyc), 32'(TMO + 1));
    end else if (len < 1 || len > NE) begin
      check({tag, "_direct_done"}, 32'(waited), 32'd0);
    end
    check({tag, "_addr_cleared"}, 32'(user_addr_out), 32'd0);
    check({tag, "_data_cleared"}, 32'(user_wrrd_num_out), 32'd0);
    tick();
    @(negedge clk);
    check({tag, "_idle"}, 32'(seq_busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(seq_done), 32'd0);
    check({tag, "_err_sticky"}, 32'(seq_err), 32'(exp_err));
    check({tag, "_strobes"}, 32'(strobe_cnt), 32'(n_exp));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    reset       = 1'b1;
    tbl_we      = 1'b0;
    tbl_idx     = '0;
    tbl_addr    = '0;
    tbl_data    = '0;
    seq_len     = '0;
    seq_start   = 1'b0;
    manual_done = 1'b0;
    stall_on    = 1'b0;
    stall_addr  = '0;

    m_addr[0] = rd_addr(ADC_CRM_ADDR); m_data[0] = ADC_MODE_WORD;
    m_addr[1] = 8'h08;                 m_data[1] = 16'h0001;
    m_addr[2] = 8'h10;                 m_data[2] = 16'h00FF;
    for (int i = 3; i < NE; i++) begin
      m_addr[i] = 8'h20 + 8'(i);
      m_data[i] = 16'h1111 * 16'(i);
    end

    vecs[0] = '{3, -1, 1'b0, 0};
    vecs[1] = '{0, -1, 1'b0, 0};
    vecs[2] = '{3,  1, 1'b1, 1};
    vecs[3] = '{8, -1, 1'b0, 0};
    vecs[4] = '{9, -1, 1'b0, 0};
    vecs[5] = '{1, -1, 1'b0, 0};
    vecs[6] = '{5,  4, 1'b1, 4};
    vecs[7] = '{2, -1, 1'b0, 0};
    vecs[8] = '{2,  5, 1'b0, 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'(user_cmd_en_out), 32'd0);
    check("rst_addr", 32'(user_addr_out), 32'd0);
    check("rst_data", 32'(user_wrrd_num_out), 32'd0);
    check("rst_busy", 32'(seq_busy), 32'd0);
    check("rst_done", 32'(seq_done), 32'd0);
    check("rst_err", 32'(seq_err), 32'd0);
    check("rst_err_idx", 32'(err_idx), 32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < NE; i++) wr(i, m_addr[i], m_data[i]);

    for (int v = 0; v < 9; v++)
      run_seq(vecs[v].len, vecs[v].stall, vecs[v].exp_err, vecs[v].exp_eidx, 0,
              $sformatf("vec%0d", v));

    // Reset while waiting on entry 2, then restart with the table intact
    tick();
    exp_q.delete();
    strobe_cnt = 0;
    stall_on   = 1'b0;
    push_exp(3, -1);
    seq_len   = 4'd3;
    seq_start = 1'b1;
    tick();
    seq_start = 1'b0;
    w = 0;
    while (strobe_cnt < 3 && w < 200) begin
      tick();
      w++;
    end
    check("midrst_reached_entry2", 32'(strobe_cnt), 32'd3);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_en", 32'(user_cmd_en_out), 32'd0);
    check("midrst_addr", 32'(user_addr_out), 32'd0);
    check("midrst_data", 32'(user_wrrd_num_out), 32'd0);
    check("midrst_busy", 32'(seq_busy), 32'd0);
    check("midrst_done", 32'(seq_done), 32'd0);
    run_seq(3, -1, 1'b0, 0, 0, "restart");

    // Table write and start while busy must not disturb anything
    run_seq(3, -1, 1'b0, 0, 1, "busy_inject");
    run_seq(1, -1, 1'b0, 0, 0, "table_kept");

    // Done pulse during the strobe cycle is ignored: entry 0 times out
    run_seq(2, 0, 1'b1, 0, 2, "early_done");

    // Recovery after an error
    run_seq(3, -1, 1'b0, 0, 0, "recover");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
